// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-port memory responder.
// Holds the FSM state encoding and the address legality check.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int ADDR_LSB = 2;
    localparam int WORD_W   = 32;

    // Returns {misaligned, out_of_range}; aw is log2 of the word count.
    function automatic logic [1:0] addr_check(input logic [WORD_W-1:0] addr, input int aw);
        logic [WORD_W-1:0] hi;
        hi = addr >> (aw + ADDR_LSB);
        return {addr[ADDR_LSB-1:0] != '0, hi != '0};
    endfunction

endpackage

// File: rtl/dmr_storage.sv
// Word-organised storage: synchronous write, registered read, async clear.
// rd_zero forces the read register to 0 for stores and faulted accesses.
module dmr_storage
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[addr] <= wdata;
            if (rd_en) rdata <= rd_zero ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: one request at a time, WAIT_STATES cycles of
// latency, flags misaligned/out-of-range accesses instead of aliasing them.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_t            state, state_nxt;
    logic              run;
    logic [CNT_W-1:0]  wait_cnt;
    logic              write_q;
    logic [WORD_W-1:0] addr_q, wdata_q;
    logic              accept, go_resp, resp_hs;
    logic              cur_write;
    logic [WORD_W-1:0] cur_addr, cur_wdata;
    logic [1:0]        chk;
    logic              err;

    assign req_ready = run && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign resp_hs   = (state == RESP) && resp_ready;

    // With zero wait states the access resolves on the accept edge itself,
    // so the live request fields stand in for the not-yet-latched copies.
    assign cur_write = (state == IDLE) ? req_write : write_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign chk       = addr_check(cur_addr, AW);
    assign err       = |chk;

    always_comb begin
        state_nxt = state;
        go_resp   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (WAIT_STATES == 0) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: if (wait_cnt == '0) begin
                state_nxt = RESP;
                go_resp   = 1'b1;
            end
            RESP: if (resp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= CNT_W'(WAIT_STATES - 1);
                write_q  <= req_write;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (go_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= err;
            end else if (resp_hs) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
            end
        end
    end

    dmr_storage #(.DEPTH_WORDS(DEPTH_WORDS)) u_storage (
        .clk     (clk),
        .rst     (rst),
        .we      (go_resp && cur_write && !err),
        .rd_en   (go_resp),
        .rd_zero (cur_write || err),
        .addr    (cur_addr[AW+ADDR_LSB-1:ADDR_LSB]),
        .wdata   (cur_wdata),
        .rdata   (resp_rdata)
    );

endmodule
